// File: rtl/mem_port_ctrl.sv
// Byte-serial memory port: serves instruction fetches and 1/2/4-byte loads/stores
// over one byte-wide synchronous RAM. Optional build macro: IO_STALL_EN.
module mem_port_ctrl #(
  parameter int                ADDR_W  = 32,
  parameter int                DATA_W  = 32,
  parameter logic [ADDR_W-1:0] IO_ADDR = ADDR_W'(32'h30000)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              inst_read_enable,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic [DATA_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_addr_o,
  output logic              inst_done,
  input  logic              data_req,
  input  logic              data_we,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [1:0]        data_size,
  input  logic [DATA_W-1:0] data_wdata,
  output logic [DATA_W-1:0] data_rdata,
  output logic              data_done,
  input  logic [7:0]        mem_din,
  output logic [7:0]        mem_dout,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_wr,
  input  logic              io_buffer_full
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE} state_t;

  state_t            r_state, w_state_n;
  logic [2:0]        r_cnt, w_cnt_n;
  logic [2:0]        r_len, w_len_n, w_req_len;
  logic [1:0]        w_cap_sel;
  logic [ADDR_W-1:0] r_addr, w_addr_n;
  logic [ADDR_W-1:0] r_hold_a, w_live_a;
  logic [ADDR_W-1:0] r_inst_addr, w_inst_addr_n;
  logic [DATA_W-1:0] r_wdata, w_wdata_n;
  logic [DATA_W-1:0] r_buf, w_buf_n;
  logic [DATA_W-1:0] r_inst, w_inst_n;
  logic [DATA_W-1:0] r_rdata, w_rdata_n;
  logic              r_fetch, w_fetch_n;
  logic              r_inst_done, w_inst_done_n;
  logic              r_data_done, w_data_done_n;
  logic              w_issuing, w_store_ok, w_io_hold;

  always_comb begin
    unique case (data_size)
      2'b00:   w_req_len = 3'd1;
      2'b01:   w_req_len = 3'd2;
      default: w_req_len = 3'd4;
    endcase
  end

  // READ issues addresses for cnt < len; the cnt == len cycle only captures the last byte.
  assign w_issuing = (r_state == S_WRITE) || ((r_state == S_READ) && (r_cnt != r_len));
  assign w_live_a  = w_issuing ? r_addr + ADDR_W'(r_cnt) : '0;
  assign w_cap_sel = r_cnt[1:0] - 2'd1;

`ifdef IO_STALL_EN
  assign w_store_ok = !(data_we && (data_addr >= IO_ADDR) && io_buffer_full);
  assign w_io_hold  = (r_state == S_WRITE) && (w_live_a >= IO_ADDR) && io_buffer_full;
`else
  logic w_unused_io;
  assign w_unused_io = io_buffer_full;
  assign w_store_ok  = 1'b1;
  assign w_io_hold   = 1'b0;
`endif

  // While stalled the RAM keeps seeing the last issued address, so the byte
  // captured on resume is the one that was in flight when rdy dropped.
  assign mem_a    = rdy ? w_live_a : r_hold_a;
  assign mem_wr   = rdy && (r_state == S_WRITE) && !w_io_hold;
  assign mem_dout = (r_state == S_WRITE) ? r_wdata[{r_cnt[1:0], 3'b000} +: 8] : 8'h00;

  assign inst        = r_inst;
  assign inst_addr_o = r_inst_addr;
  assign inst_done   = r_inst_done;
  assign data_rdata  = r_rdata;
  assign data_done   = r_data_done;

  always_comb begin
    // NOTE: every next-state variable gets a default first so no path can infer a latch.
    w_state_n     = r_state;
    w_cnt_n       = r_cnt;
    w_len_n       = r_len;
    w_addr_n      = r_addr;
    w_wdata_n     = r_wdata;
    w_fetch_n     = r_fetch;
    w_buf_n       = r_buf;
    w_inst_n      = r_inst;
    w_inst_addr_n = r_inst_addr;
    w_rdata_n     = r_rdata;
    w_inst_done_n = 1'b0;
    w_data_done_n = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        if (data_req && w_store_ok) begin
          w_state_n = data_we ? S_WRITE : S_READ;
          w_cnt_n   = 3'd0;
          w_len_n   = w_req_len;
          w_addr_n  = data_addr;
          w_wdata_n = data_wdata;
          w_fetch_n = 1'b0;
          w_buf_n   = '0;
        end else if (inst_read_enable) begin
          w_state_n = S_READ;
          w_cnt_n   = 3'd0;
          w_len_n   = 3'd4;
          w_addr_n  = inst_addr;
          w_fetch_n = 1'b1;
          w_buf_n   = '0;
        end
      end

      S_READ: begin
        if (r_cnt != 3'd0) begin
          w_buf_n[{w_cap_sel, 3'b000} +: 8] = mem_din;
        end
        if (r_cnt == r_len) begin
          w_state_n = S_IDLE;
          if (r_fetch) begin
            w_inst_n      = w_buf_n;
            w_inst_addr_n = r_addr;
            w_inst_done_n = 1'b1;
          end else begin
            w_rdata_n     = w_buf_n;
            w_data_done_n = 1'b1;
          end
        end else begin
          w_cnt_n = r_cnt + 3'd1;
        end
      end

      S_WRITE: begin
        if (!w_io_hold) begin
          if (r_cnt == r_len - 3'd1) begin
            w_state_n     = S_IDLE;
            w_data_done_n = 1'b1;
          end else begin
            w_cnt_n = r_cnt + 3'd1;
          end
        end
      end

      default: w_state_n = S_IDLE;
    endcase
  end

  // NOTE: state registers take non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_len       <= '0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_fetch     <= 1'b0;
      r_buf       <= '0;
      r_hold_a    <= '0;
      r_inst      <= '0;
      r_inst_addr <= '0;
      r_rdata     <= '0;
      r_inst_done <= 1'b0;
      r_data_done <= 1'b0;
    end else if (rdy) begin
      r_state     <= w_state_n;
      r_cnt       <= w_cnt_n;
      r_len       <= w_len_n;
      r_addr      <= w_addr_n;
      r_wdata     <= w_wdata_n;
      r_fetch     <= w_fetch_n;
      r_buf       <= w_buf_n;
      r_hold_a    <= w_live_a;
      r_inst      <= w_inst_n;
      r_inst_addr <= w_inst_addr_n;
      r_rdata     <= w_rdata_n;
      r_inst_done <= w_inst_done_n;
      r_data_done <= w_data_done_n;
    end
  end

endmodule

// File: tb/tb_mem_port_ctrl.sv
// Self-checking bench for mem_port_ctrl: directed scenarios plus randomized accesses
// against a byte-array reference model. IO_STALL_EN adds the IO back-pressure scenario.
module tb_mem_port_ctrl;

  logic        clk;
  logic        rst;
  logic        rdy;
  logic        inst_read_enable;
  logic [31:0] inst_addr;
  logic [31:0] inst;
  logic [31:0] inst_addr_o;
  logic        inst_done;
  logic        data_req;
  logic        data_we;
  logic [31:0] data_addr;
  logic [1:0]  data_size;
  logic [31:0] data_wdata;
  logic [31:0] data_rdata;
  logic        data_done;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full;

  mem_port_ctrl dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .inst_read_enable(inst_read_enable), .inst_addr(inst_addr),
    .inst(inst), .inst_addr_o(inst_addr_o), .inst_done(inst_done),
    .data_req(data_req), .data_we(data_we), .data_addr(data_addr),
    .data_size(data_size), .data_wdata(data_wdata),
    .data_rdata(data_rdata), .data_done(data_done),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0;
  int bad   = 0;

  // RAM model: 8 KiB array covering every address region the bench touches.
  logic [7:0]  ram [0:8191];
  logic        ram_load;
  logic [7:0]  ref_mem [logic [31:0]];
  logic [31:0] tr_a  [0:63];
  logic        tr_wr [0:63];
  logic [7:0]  tr_do [0:63];

  function automatic logic [12:0] idx(input logic [31:0] a);
    return {a[16], a[11:0]};
  endfunction

  function automatic logic [7:0] hash_b(input logic [12:0] x);
    return x[7:0] ^ {x[11:8], x[12], x[10:8]} ^ 8'h5A;
  endfunction

  function automatic logic [7:0] base_b(input logic [31:0] a);
    case (a)
      32'h100: return 8'h13;
      32'h101: return 8'h05;
      32'h102: return 8'hA0;
      32'h103: return 8'h00;
      32'h3FF: return 8'h80;
      default: return hash_b(idx(a));
    endcase
  endfunction

  function automatic logic [7:0] ref_b(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : base_b(a);
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] a, input int w);
    logic [31:0] r = '0;
    for (int k = 0; k < w; k++) r[8*k +: 8] = ref_b(a + 32'(k));
    return r;
  endfunction

  always @(posedge clk) begin
    if (ram_load) begin
      for (int i = 0; i < 8192; i++) begin
        ram[i] <= base_b({15'b0, i[12], 4'b0, i[11:0]});
      end
    end else begin
      mem_din <= ram[idx(mem_a)];
      if (mem_wr) ram[idx(mem_a)] <= mem_dout;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_inst"}, inst, 32'h0);
    check({tag, "_inst_addr_o"}, inst_addr_o, 32'h0);
    check({tag, "_inst_done"}, 32'(inst_done), 32'h0);
    check({tag, "_data_rdata"}, data_rdata, 32'h0);
    check({tag, "_data_done"}, 32'(data_done), 32'h0);
    check({tag, "_mem_a"}, mem_a, 32'h0);
    check({tag, "_mem_wr"}, 32'(mem_wr), 32'h0);
    check({tag, "_mem_dout"}, 32'(mem_dout), 32'h0);
  endtask

  task automatic start(input bit fetch, input bit we, input logic [31:0] a,
                       input logic [1:0] sz, input logic [31:0] wd);
    if (fetch) begin
      inst_read_enable = 1'b1;
      inst_addr        = a;
    end else begin
      data_req   = 1'b1;
      data_we    = we;
      data_addr  = a;
      data_size  = sz;
      data_wdata = wd;
    end
  endtask

  // Runs cycles N+1..N+budget after a request driven in cycle N; records the RAM
  // bus per cycle and the cycle offset of each done pulse, dropping a request when done.
  task automatic run(input int budget, input int stall_from, input int stall_len,
                     input int full_len, output int t_inst, output int t_data,
                     output int n_inst, output int n_data);
    t_inst = -1; t_data = -1; n_inst = 0; n_data = 0;
    for (int i = 0; i < 64; i++) begin
      tr_a[i] = '0; tr_wr[i] = 1'b0; tr_do[i] = '0;
    end
    for (int c = 1; c <= budget; c++) begin
      @(posedge clk); #1;
      rdy            = !(c >= stall_from && c < stall_from + stall_len);
      io_buffer_full = (c < full_len);
      #1;
      if (c < 64) begin
        tr_a[c] = mem_a; tr_wr[c] = mem_wr; tr_do[c] = mem_dout;
      end
      if (inst_done) begin
        n_inst++;
        if (t_inst < 0) t_inst = c;
        inst_read_enable = 1'b0;
      end
      if (data_done) begin
        n_data++;
        if (t_data < 0) t_data = c;
        data_req = 1'b0;
      end
    end
    inst_read_enable = 1'b0;
    data_req         = 1'b0;
    rdy              = 1'b1;
    io_buffer_full   = 1'b0;
  endtask

  function automatic int wr_count(input int from, input int to);
    int n = 0;
    for (int c = from; c <= to; c++) n += int'(tr_wr[c]);
    return n;
  endfunction

  initial begin
    #400000;
    $display("FAIL watchdog expired before the end of the test sequence");
    $fatal(1);
  end

  initial begin
    int ti, td, ni, nd;
    int kind, w, s_from, s_len, lat;
    logic [1:0]  sz;
    logic [31:0] a, wd, exp_w;

    rst = 1'b1; rdy = 1'b1; ram_load = 1'b1;
    inst_read_enable = 1'b0; inst_addr = '0;
    data_req = 1'b0; data_we = 1'b0; data_addr = '0; data_size = '0; data_wdata = '0;
    io_buffer_full = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    ram_load = 1'b0;
    check_outputs_zero("reset");
    rst = 1'b0;

    // Fetch of 0x100 from the preloaded instruction bytes.
    @(posedge clk); #1;
    start(1'b1, 1'b0, 32'h100, 2'b10, '0);
    run(10, 0, 0, 0, ti, td, ni, nd);
    for (int k = 0; k < 4; k++) check($sformatf("fetch_mem_a%0d", k), tr_a[k+1], 32'h100 + 32'(k));
    check("fetch_no_wr", 32'(wr_count(1, 9)), 32'h0);
    check("fetch_done_cycle", 32'(ti), 32'd6);
    check("fetch_done_count", 32'(ni), 32'd1);
    check("fetch_word", inst, 32'h00A00513);
    check("fetch_addr_o", inst_addr_o, 32'h100);
    check("fetch_idle_mem_a", tr_a[9], 32'h0);

    // Simultaneous load and fetch: the load wins, the fetch follows.
    @(posedge clk); #1;
    start(1'b0, 1'b0, 32'h200, 2'b10, '0);
    start(1'b1, 1'b0, 32'h104, 2'b10, '0);
    run(16, 0, 0, 0, ti, td, ni, nd);
    check("arb_load_done_cycle", 32'(td), 32'd6);
    check("arb_fetch_done_cycle", 32'(ti), 32'd12);
    check("arb_load_word", data_rdata, ref_word(32'h200, 4));
    check("arb_fetch_word", inst, ref_word(32'h104, 4));
    check("arb_fetch_addr_o", inst_addr_o, 32'h104);

    // Halfword store.
    @(posedge clk); #1;
    start(1'b0, 1'b1, 32'h300, 2'b01, 32'hDEADBEEF);
    run(8, 0, 0, 0, ti, td, ni, nd);
    ref_mem[32'h300] = 8'hEF;
    ref_mem[32'h301] = 8'hBE;
    check("sh_wr1", 32'(tr_wr[1]), 32'h1);
    check("sh_a1", tr_a[1], 32'h300);
    check("sh_d1", 32'(tr_do[1]), 32'hEF);
    check("sh_wr2", 32'(tr_wr[2]), 32'h1);
    check("sh_a2", tr_a[2], 32'h301);
    check("sh_d2", 32'(tr_do[2]), 32'hBE);
    check("sh_wr3", 32'(tr_wr[3]), 32'h0);
    check("sh_done_cycle", 32'(td), 32'd3);
    check("sh_ram_300", 32'(ram[idx(32'h300)]), 32'(ref_b(32'h300)));
    check("sh_ram_302", 32'(ram[idx(32'h302)]), 32'(ref_b(32'h302)));

    // Byte load zero-extends; the fetched word from earlier is still held.
    @(posedge clk); #1;
    start(1'b0, 1'b0, 32'h3FF, 2'b00, '0);
    run(8, 0, 0, 0, ti, td, ni, nd);
    check("lb_word", data_rdata, 32'h00000080);
    check("lb_done_cycle", 32'(td), 32'd3);
    check("inst_held", inst, ref_word(32'h104, 4));

    // rdy low for three cycles while byte 2 of a fetch is due.
    @(posedge clk); #1;
    start(1'b1, 1'b0, 32'h120, 2'b10, '0);
    run(16, 3, 3, 0, ti, td, ni, nd);
    check("stall_done_cycle", 32'(ti), 32'd9);
    check("stall_word", inst, ref_word(32'h120, 4));
    check("stall_no_wr", 32'(wr_count(1, 15)), 32'h0);
    for (int c = 3; c <= 5; c++) check($sformatf("stall_hold_a%0d", c), tr_a[c], 32'h121);
    check("stall_resume_a", tr_a[6], 32'h122);

    // Reset pulsed mid-fetch.
    @(posedge clk); #1;
    start(1'b1, 1'b0, 32'h140, 2'b10, '0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    inst_read_enable = 1'b0;
    @(posedge clk); #2;
    check_outputs_zero("midrst");
    rst = 1'b0;
    run(10, 0, 0, 0, ti, td, ni, nd);
    check("midrst_no_inst_done", 32'(ni), 32'h0);
    check("midrst_no_data_done", 32'(nd), 32'h0);

`ifdef IO_STALL_EN
    // Store to the IO region held off while the IO buffer is full.
    @(posedge clk); #1;
    io_buffer_full = 1'b1;
    start(1'b0, 1'b1, 32'h30000, 2'b00, 32'h0000005A);
    run(12, 0, 0, 5, ti, td, ni, nd);
    ref_mem[32'h30000] = 8'h5A;
    check("io_no_wr_while_full", 32'(wr_count(1, 5)), 32'h0);
    check("io_wr_after_clear", 32'(tr_wr[6]), 32'h1);
    check("io_wr_addr", tr_a[6], 32'h30000);
    check("io_done_cycle", 32'(td), 32'd7);
    check("io_ram", 32'(ram[idx(32'h30000)]), 32'h5A);
`endif

    // Randomized single accesses, optional rdy stall inside the active window.
    for (int it = 0; it < 24; it++) begin
      kind   = int'($urandom_range(0, 2));
      sz     = 2'($urandom_range(0, 3));
      w      = (kind == 0) ? 4 : (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
      a      = ($urandom_range(0, 5) == 0) ? 32'hFFFF_FFFC + 32'($urandom_range(0, 3))
                                           : 32'h400 + 32'($urandom_range(0, 255));
      wd     = $urandom;
      s_len  = int'($urandom_range(0, 3));
      s_from = 1 + int'($urandom_range(0, w - 1));
      lat    = ((kind == 2) ? w + 1 : w + 2) + s_len;
      exp_w  = ref_word(a, w);

      @(posedge clk); #1;
      start(kind == 0, kind == 2, a, sz, wd);
      run(lat + 4, s_from, s_len, 0, ti, td, ni, nd);

      if (kind == 0) begin
        check($sformatf("rnd%0d_fetch_lat", it), 32'(ti), 32'(lat));
        check($sformatf("rnd%0d_fetch_word", it), inst, exp_w);
        check($sformatf("rnd%0d_fetch_addr", it), inst_addr_o, a);
        check($sformatf("rnd%0d_fetch_ndone", it), 32'(ni), 32'd1);
      end else if (kind == 1) begin
        check($sformatf("rnd%0d_load_lat", it), 32'(td), 32'(lat));
        check($sformatf("rnd%0d_load_word", it), data_rdata, exp_w);
        check($sformatf("rnd%0d_load_ndone", it), 32'(nd), 32'd1);
      end else begin
        for (int k = 0; k < w; k++) ref_mem[a + 32'(k)] = wd[8*k +: 8];
        check($sformatf("rnd%0d_store_lat", it), 32'(td), 32'(lat));
        check($sformatf("rnd%0d_store_nwr", it), 32'(wr_count(1, lat + 3)), 32'(w));
        for (int k = 0; k < w; k++) begin
          check($sformatf("rnd%0d_store_ram%0d", it, k),
                32'(ram[idx(a + 32'(k))]), 32'(ref_b(a + 32'(k))));
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
